// File: rtl/uio_bank_pkg.sv
// Shared command/mode encodings for the user-IO bank controller.
package uio_bank_pkg;

    localparam int OP_W   = 2;
    localparam int MODE_W = 2;

    typedef enum logic [OP_W-1:0] {
        WR_OUT  = 2'd0,
        WR_OE   = 2'd1,
        WR_DIV  = 2'd2,
        WR_MODE = 2'd3
    } cmd_op_e;

    typedef enum logic [MODE_W-1:0] {
        STATIC = 2'd0,
        TOGGLE = 2'd1,
        WALK   = 2'd2,
        SAMPLE = 2'd3
    } mode_e;

endpackage

// File: rtl/uio_prescaler.sv
// Down-counting prescaler: one tick every div+1 enabled cycles, reloadable on demand.
module uio_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             reload,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = en & (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            // A reload restarts the period even when it lands on a tick cycle.
            if (reload || count == '0) begin
                count <= div;
            end else begin
                count <= count - {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/uio_bank_ctrl.sv
// Register-driven controller for a bidirectional user-IO bank with
// static, toggle, walking-one and input-sampling modes.
module uio_bank_ctrl
    import uio_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    function automatic logic [WIDTH-1:0] walk_next(input logic [WIDTH-1:0] v);
        if (v == '0) begin
            return {{(WIDTH-1){1'b0}}, 1'b1};
        end
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    cmd_op_e          op;
    mode_e            mode_q;
    logic             pending;
    logic             accept;
    logic             reload;
    logic             tick;
    logic [DIV_W-1:0] data_div;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_nxt;
    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] rd_q;
    logic             rd_vld_q;

    generate
        if (DIV_W > WIDTH) begin : g_div_ext
            assign data_div = {{(DIV_W-WIDTH){1'b0}}, cmd_data};
        end else begin : g_div_trunc
            assign data_div = cmd_data[DIV_W-1:0];
        end
    endgenerate

    assign op        = cmd_op_e'(cmd_op);
    assign cmd_ready = rst_n & ena & ~pending;
    assign accept    = cmd_valid & cmd_ready;
    assign reload    = accept & (op == WR_DIV || op == WR_MODE);
    // The prescaler must reload with the value being written, not the old div.
    assign div_nxt   = (accept && op == WR_DIV) ? data_div : div_q;

    uio_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (ena),
        .reload (reload),
        .div    (div_nxt),
        .tick   (tick)
    );

    // Stage p0/p1: two-flop synchroniser for the asynchronous pad input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else if (ena) begin
            sync_p0 <= pin_in;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            div_q   <= '0;
            mode_q  <= STATIC;
            oe_q    <= '0;
        end else if (ena) begin
            pending <= accept;
            if (accept && op == WR_DIV) begin
                div_q <= data_div;
            end
            if (accept && op == WR_MODE) begin
                mode_q <= mode_e'(cmd_data[MODE_W-1:0]);
            end
            if (accept && op == WR_OE) begin
                oe_q <= cmd_data;
            end
        end
    end

    // An accepted WR_OUT overrides whatever the mode would do on this tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (accept && op == WR_OUT) begin
            out_q <= cmd_data;
        end else if (tick && mode_q == TOGGLE) begin
            out_q <= ~out_q;
        end else if (tick && mode_q == WALK) begin
            out_q <= walk_next(out_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= tick & (mode_q == SAMPLE);
            if (tick && mode_q == SAMPLE) begin
                rd_q <= sync_p1;
            end
        end
    end

    assign pin_out  = out_q;
    assign pin_oe   = oe_q;
    assign rd_data  = rd_q;
    assign rd_valid = rd_vld_q & ena;

endmodule

// File: tb/tb_uio_bank_ctrl.sv
// Self-checking bench for uio_bank_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_uio_bank_ctrl;

    localparam int WIDTH = 8;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] pin_out;
    logic [WIDTH-1:0] pin_oe;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    uio_bank_ctrl #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int m_out, m_oe, m_rd, m_div, m_mode, m_s1, m_s2;
    int m_e, m_first;
    bit m_rdv, m_pend;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rotl8(input int v);
        return ((v * 2) % 256) + (v / 128);
    endfunction

    task automatic model_reset();
        m_out = 0; m_oe = 0; m_rd = 0; m_rdv = 0; m_div = 0; m_mode = 0;
        m_s1 = 0; m_s2 = 0; m_e = 0; m_first = 0; m_pend = 0;
    endtask

    task automatic drive_idle();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 8'($urandom);
    endtask

    task automatic check_regs();
        check_eq("pin_out",  32'(pin_out),  32'(m_out));
        check_eq("pin_oe",   32'(pin_oe),   32'(m_oe));
        check_eq("rd_data",  32'(rd_data),  32'(m_rd));
        check_eq("rd_valid", 32'(rd_valid), 32'(m_rdv & ena));
    endtask

    // Called at a negedge with inputs already driven; advances one clock.
    task automatic cycle(output bit acc);
        bit tk;
        #1;
        check_eq("cmd_ready", 32'(cmd_ready), 32'(ena & ~m_pend));
        acc = ena && cmd_valid && !m_pend;
        @(posedge clk);
        if (ena) begin
            tk = (m_e >= m_first) && (((m_e - m_first) % (m_div + 1)) == 0);
            m_rdv = tk && (m_mode == 3);
            if (m_rdv) m_rd = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(pin_in);
            if (acc && cmd_op == 2'd0)      m_out = int'(cmd_data);
            else if (tk && m_mode == 1)     m_out = 255 - m_out;
            else if (tk && m_mode == 2)     m_out = (m_out == 0) ? 1 : rotl8(m_out);
            if (acc && cmd_op == 2'd1) m_oe = int'(cmd_data);
            if (acc && cmd_op == 2'd2) begin
                m_div = int'(cmd_data);
                m_first = m_e + 1 + m_div;
            end
            if (acc && cmd_op == 2'd3) begin
                m_mode = int'(cmd_data) % 4;
                m_first = m_e + 1 + m_div;
            end
            m_pend = acc;
            m_e++;
        end else begin
            m_rdv = 1'b0;
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] data, output int tries);
        bit acc;
        acc = 1'b0;
        tries = 0;
        ena = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = data;
        for (int i = 0; i < 4 && !acc; i++) begin
            cycle(acc);
            tries++;
        end
        check_eq("send_accepted", 32'(acc), 32'd1);
        drive_idle();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_pin_out",   32'(pin_out),   32'd0);
        check_eq("arst_pin_oe",    32'(pin_oe),    32'd0);
        check_eq("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("arst_rd_valid",  32'(rd_valid),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit dmy;
        int tries;
        int pulses;

        rst_n = 1'b0;
        ena = 1'b1;
        pin_in = '0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_pin_oe",    32'(pin_oe),    32'd0);
        check_eq("rst_pin_out",   32'(pin_out),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cycle(dmy);

        // Back-to-back commands: the second is held off one cycle
        send(2'd1, 8'hFF, tries);
        send(2'd0, 8'hA5, tries);
        check_eq("held_off_tries", 32'(tries), 32'd2);
        check_eq("oe_ff",  32'(pin_oe),  32'hFF);
        check_eq("out_a5", 32'(pin_out), 32'hA5);

        // Toggle with div=3: first change 4 cycles after the mode write
        send(2'd2, 8'd3, tries);
        send(2'd3, 8'd1, tries);
        repeat (3) cycle(dmy);
        check_eq("toggle_before", 32'(pin_out), 32'hA5);
        cycle(dmy);
        check_eq("toggle_first", 32'(pin_out), 32'h5A);
        repeat (4) cycle(dmy);
        check_eq("toggle_second", 32'(pin_out), 32'hA5);

        // Walking one at full rate
        send(2'd3, 8'd0, tries);
        send(2'd0, 8'h00, tries);
        send(2'd2, 8'd0, tries);
        send(2'd3, 8'd2, tries);
        check_eq("walk_start", 32'(pin_out), 32'd0);
        for (int k = 0; k < 9; k++) begin
            cycle(dmy);
            check_eq("walk_step", 32'(pin_out), 32'(1 << (k % 8)));
        end

        // Sampling with div=1
        pin_in = 8'h3C;
        send(2'd2, 8'd1, tries);
        send(2'd3, 8'd3, tries);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(dmy);
            if (rd_valid) pulses++;
        end
        check_eq("sample_pulses", 32'(pulses), 32'd6);
        check_eq("sample_data",   32'(rd_data), 32'h3C);

        // Toggle, freeze with ena low, then asynchronous reset mid-period
        send(2'd2, 8'd3, tries);
        send(2'd3, 8'd1, tries);
        repeat (3) cycle(dmy);
        ena = 1'b0;
        repeat (5) cycle(dmy);
        ena = 1'b1;
        repeat (2) cycle(dmy);
        async_reset();
        repeat (3) cycle(dmy);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            ena = ($urandom % 10) != 0;
            cmd_valid = 1'($urandom);
            cmd_op = 2'($urandom);
            cmd_data = (cmd_op == 2'd2) ? 8'($urandom_range(0, 5)) : 8'($urandom);
            if ($urandom % 4 == 0) pin_in = 8'($urandom);
            cycle(dmy);
            if ($urandom % 400 == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uio_bank_ctrl.md
# uio_bank_ctrl

- Parametrised, register-driven controller for a bidirectional user-IO bank.
- Replaces hard-wired "all outputs low, all pins input" tie-offs with per-pin output data and output-enable registers, loaded through a valid/ready command port.
- Adds three timed modes: toggle, walking-one and input sampling, paced by a programmable prescaler.
- Sits between the project top level and the uio_out/uio_oe/uio_in pads.

## Interface
Parameters:
- WIDTH, 8, number of IO pins in the bank (≥2).
- DIV_W, 8, prescaler width in bits.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  block enable; low freezes all state.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  0=WR_OUT, 1=WR_OE, 2=WR_DIV, 3=WR_MODE.
- cmd_data  in  WIDTH  payload. WR_DIV uses [DIV_W-1:0], zero-extended when DIV_W>WIDTH. WR_MODE uses [1:0].
- pin_in  in  WIDTH  pad input, asynchronous to clk.
- pin_out  out  WIDTH  pad output data.
- pin_oe  out  WIDTH  pad output enable, 1=drive.
- rd_data  out  WIDTH  last sampled pin value.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.

## Operation
- Reset values:
  - pin_out=0, pin_oe=0 (all pins input), rd_data=0, rd_valid=0.
  - div=0, mode=STATIC, prescaler count=0, pending=0.
  - cmd_ready=0 while rst_n low.
- Handshake:
  - cmd_ready = ena & ~pending.
  - On accept, pending sets for exactly one cycle, so the maximum rate is one command per 2 cycles.
  - The effect is visible on the cycle after accept.
- Commands:
  - WR_OUT: pin_out ← data.
  - WR_OE: pin_oe ← data.
  - WR_DIV: div ← data; prescaler count reloads to the new div.
  - WR_MODE: mode ← data[1:0]; prescaler count reloads.
- Prescaler:
  - Down-counter with ena high.
  - At count==0 it asserts an internal tick and reloads div.
  - Tick period is div+1 cycles; div=0 gives a tick every cycle.
- Modes (act on tick):
  - STATIC(0): no change.
  - TOGGLE(1): pin_out ← ~pin_out.
  - WALK(2): pin_out ← rotate-left-by-1. If pin_out==0 on the tick, it becomes 1 (bit 0).
  - SAMPLE(3): rd_data ← synchronised pin_in; rd_valid pulses.
- pin_in always passes through a 2-flop synchroniser before use.
- pin_oe is never changed by the modes; only WR_OE changes it.
- Boundary conditions:
  - Tick on the same cycle as an accepted WR_OUT: the command wins and the tick update is discarded.
  - Accepted WR_DIV/WR_MODE on a tick cycle: the tick action still applies under the old mode; the count reloads to the new div.
  - ena low: no ticks, count frozen, rd_valid=0, cmd_ready=0; outputs hold.
  - rst_n asserted mid-operation: all state returns to reset values immediately, asynchronously. Pins are released (pin_oe=0) without waiting for clk.
  - cmd_op/cmd_data are ignored unless the command is accepted.

## Timing
- Command → register output: 1 cycle after the accept edge.
- TOGGLE/WALK with div=D: pin_out changes every D+1 cycles. The first change comes D+1 cycles after the WR_MODE accept.
- SAMPLE: a pin_in change reaches rd_data after 2 sync cycles plus up to D+1 cycles. rd_valid is high for exactly 1 cycle per tick.
- Deassertion of rst_n is synchronised outside this block; reset release is assumed clean.

## Structure
- Package uio_bank_pkg holds:
  - cmd_op_e (WR_OUT, WR_OE, WR_DIV, WR_MODE).
  - mode_e (STATIC, TOGGLE, WALK, SAMPLE).
  - OP_W=2 and MODE_W=2 constants.
- Sub-module uio_prescaler (DIV_W):
  - Inputs: clk, rst_n, en, reload, div.
  - Output: tick.
- Everything else (synchroniser, registers, mode logic, handshake) lives in uio_bank_ctrl.

## Test plan
- Reset, then idle 10 cycles → pin_out=0x00, pin_oe=0x00, rd_valid never high, cmd_ready=1 from the first cycle after release.
- WR_OE 0xFF, WR_OUT 0xA5 on consecutive valid cycles → second command held off one cycle (cmd_ready=0); pin_oe=0xFF, then pin_out=0xA5.
- WR_DIV 3, WR_MODE TOGGLE with pin_out=0xA5 → pin_out alternates 0x5A/0xA5 every 4 cycles.
- WR_OUT 0x00, WR_DIV 0, WR_MODE WALK → pin_out sequence 0x01, 0x02, 0x04 … 0x80, 0x01 on successive cycles.
- WR_DIV 1, WR_MODE SAMPLE, drive pin_in=0x3C → rd_valid pulses every 2 cycles; rd_data=0x3C by the third pulse at latest.
- TOGGLE running, drop ena 5 cycles, then assert rst_n low mid-period → pin_out frozen while ena low; on reset, pin_out=0 and pin_oe=0 before the next clk edge.
